// File: rtl/vector_capture.sv
// vector_capture -- on-chip test-vector recorder.
//
// Records packed DUT vectors into a DEPTH = 2**ADDR_W entry buffer while a
// capture session is open, then replays them in order, one vector per
// accepted read request.
//
// Ports:
//   clk, rst      clock, synchronous active-high reset
//   start         pulse: open / restart a capture session
//   stop          pulse: close the session, enter readout
//   vec_valid     store vec_in this cycle (capture only)
//   vec_in        vector to record
//   rd_req        request the next stored vector (readout only)
//   rd_valid      one-cycle strobe qualifying rd_data
//   rd_data       replayed vector (holds between strobes)
//   count         vectors stored this session, 0..DEPTH
//   busy          capture session open
//   full          count == DEPTH
//   done          readout state
//   overflow      sticky: a vector was dropped because the buffer was full
//
// Build option:
//   VCAP_DEDUP_EN  when defined, a vector equal to the last one stored in the
//                  current session is discarded without side effects.
//
// state      | meaning
// -----------+-------------------------------------------------------------
// ST_IDLE    | no session; waits for start
// ST_CAPTURE | session open; vec_valid stores into the buffer
// ST_DONE    | session closed; rd_req replays stored vectors in order

module vector_capture #(
    parameter int WIDTH  = 4,
    parameter int ADDR_W = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              stop,
    input  logic              vec_valid,
    input  logic [WIDTH-1:0]  vec_in,
    input  logic              rd_req,
    output logic              rd_valid,
    output logic [WIDTH-1:0]  rd_data,
    output logic [ADDR_W:0]   count,
    output logic              busy,
    output logic              full,
    output logic              done,
    output logic              overflow
);

    localparam int              DEPTH   = 1 << ADDR_W;
    localparam logic [ADDR_W:0] DEPTH_C = (ADDR_W + 1)'(DEPTH);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_CAPTURE,
        ST_DONE
    } state_t;

    state_t             state_q, state_d;
    // Pointers carry one extra bit so a full session never wraps them.
    logic [ADDR_W:0]    wptr_q, wptr_d;
    logic [ADDR_W:0]    rptr_q, rptr_d;
    logic [ADDR_W:0]    count_q, count_d;
    logic               overflow_q, overflow_d;
    logic               rd_valid_q, rd_valid_d;
    logic [WIDTH-1:0]   rd_data_q, rd_data_d;
    logic [WIDTH-1:0]   mem_q [DEPTH];

    logic               mem_we;
    logic               clr;
    logic               is_full;
    logic               is_dup;

`ifdef VCAP_DEDUP_EN
    logic [WIDTH-1:0]   last_q, last_d;
`endif

    always_comb begin
        state_d    = state_q;
        wptr_d     = wptr_q;
        rptr_d     = rptr_q;
        count_d    = count_q;
        overflow_d = overflow_q;
        rd_valid_d = 1'b0;
        rd_data_d  = rd_data_q;
        mem_we     = 1'b0;
        clr        = 1'b0;
        is_full    = (count_q == DEPTH_C);
        is_dup     = 1'b0;
`ifdef VCAP_DEDUP_EN
        last_d     = last_q;
        // The first vector of a session has nothing to compare against.
        is_dup     = (count_q != '0) && (vec_in == last_q);
`endif

        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d = ST_CAPTURE;
                    clr     = 1'b1;
                end
            end
            ST_CAPTURE: begin
                if (start) begin
                    clr = 1'b1;
                end else begin
                    // The store is judged on the pre-edge full flag, and a
                    // coincident stop still lets this vector in.
                    if (vec_valid && !is_dup) begin
                        if (!is_full) begin
                            mem_we  = 1'b1;
                            wptr_d  = wptr_q + 1'b1;
                            count_d = count_q + 1'b1;
`ifdef VCAP_DEDUP_EN
                            last_d  = vec_in;
`endif
                        end else begin
                            overflow_d = 1'b1;
                        end
                    end
                    if (stop) begin
                        state_d = ST_DONE;
                    end
                end
            end
            ST_DONE: begin
                if (start) begin
                    state_d = ST_CAPTURE;
                    clr     = 1'b1;
                end else if (rd_req && (rptr_q < count_q)) begin
                    rd_valid_d = 1'b1;
                    rd_data_d  = mem_q[rptr_q[ADDR_W-1:0]];
                    rptr_d     = rptr_q + 1'b1;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        if (clr) begin
            wptr_d     = '0;
            rptr_d     = '0;
            count_d    = '0;
            overflow_d = 1'b0;
`ifdef VCAP_DEDUP_EN
            last_d     = '0;
`endif
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            wptr_q     <= '0;
            rptr_q     <= '0;
            count_q    <= '0;
            overflow_q <= 1'b0;
            rd_valid_q <= 1'b0;
            rd_data_q  <= '0;
`ifdef VCAP_DEDUP_EN
            last_q     <= '0;
`endif
        end else begin
            state_q    <= state_d;
            wptr_q     <= wptr_d;
            rptr_q     <= rptr_d;
            count_q    <= count_d;
            overflow_q <= overflow_d;
            rd_valid_q <= rd_valid_d;
            rd_data_q  <= rd_data_d;
`ifdef VCAP_DEDUP_EN
            last_q     <= last_d;
`endif
        end
    end

    // Buffer contents survive reset; only the session bookkeeping is cleared.
    always_ff @(posedge clk) begin
        if (mem_we && !rst) begin
            mem_q[wptr_q[ADDR_W-1:0]] <= vec_in;
        end
    end

    assign rd_valid = rd_valid_q;
    assign rd_data  = rd_data_q;
    assign count    = count_q;
    assign overflow = overflow_q;
    assign busy     = (state_q == ST_CAPTURE);
    assign done     = (state_q == ST_DONE);
    assign full     = (count_q == DEPTH_C);

endmodule
